// File: rtl/dac_route_pkg.sv
// Shared encodings and conversion helpers for the DAC routing multiplexer.
package dac_route_pkg;

   localparam logic [1:0] MODE_BIPOLAR  = 2'd0;
   localparam logic [1:0] MODE_UNSIGNED = 2'd1;
   localparam logic [1:0] MODE_SYMBOL   = 2'd2;

   typedef enum logic {
      ST_RUN,
      ST_MUTE
   } ch_state_t;

   function automatic logic [63:0] midscale(input int dac_w);
      return 64'd1 << (dac_w - 1);
   endfunction

   // Clamp to [-MID, MID-1] then offset by MID, giving an offset-binary code.
   function automatic logic [63:0] sat_signed(input logic signed [63:0] v, input int dac_w);
      logic signed [63:0] mid;
      mid = signed'(midscale(dac_w));
      if (v > mid - 64'sd1) return mid + mid - 64'sd1;
      if (v < -mid) return 64'd0;
      return v + mid;
   endfunction

   function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int dac_w);
      logic [63:0] full;
      full = (64'd1 << dac_w) - 64'd1;
      return (v > full) ? full : v;
   endfunction

endpackage

// File: rtl/dac_route_mux_conv.sv
// Single-channel registered converter: source word plus mode -> DAC code.
module dac_sample_conv
   import dac_route_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int DAC_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mute,
   input  logic [1:0]       mode,
   input  logic             m4,
   input  logic [IN_W-1:0]  word,
   output logic [DAC_W-1:0] code
);

   localparam logic [DAC_W-1:0] MID  = DAC_W'(midscale(DAC_W));
   localparam logic [DAC_W-1:0] FULL = '1;
   localparam logic [DAC_W-1:0] STEP = FULL / DAC_W'(3);

   logic [DAC_W-1:0] conv;

   // Reserved mode 3 falls through to the bipolar default.
   always_comb begin
      conv = DAC_W'(sat_signed(64'(signed'(word)), DAC_W));
      case (mode)
         MODE_UNSIGNED: conv = DAC_W'(sat_unsigned(64'(word), DAC_W));
         MODE_SYMBOL: begin
            if (m4) conv = STEP * DAC_W'(word[1:0]);
            else    conv = word[0] ? FULL : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)   code <= MID;
      else if (en)  code <= mute ? MID : conv;
   end

endmodule

// File: rtl/dac_route_mux.sv
// Routes NUM_IN sources to NUM_OUT DAC channels with glitch-free muted switching.
//   state   | meaning
//   ST_RUN  | active source routed to the channel
//   ST_MUTE | channel held at midscale, pending source waits for the countdown
module dac_route_mux
   import dac_route_pkg::*;
#(
   parameter int NUM_IN     = 8,
   parameter int NUM_OUT    = 2,
   parameter int IN_W       = 32,
   parameter int DAC_W      = 12,
   parameter int MUTE_TICKS = 16,
   localparam int SEL_W     = $clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_en,
   input  logic [NUM_IN*IN_W-1:0]   data_in,
   input  logic [2*NUM_IN-1:0]      in_mode,
   input  logic [NUM_IN-1:0]        sym_m4,
   input  logic [NUM_OUT*SEL_W-1:0] sel,
   output logic [NUM_OUT*DAC_W-1:0] data_out,
   output logic                     out_valid,
   output logic [NUM_OUT-1:0]       muting,
   output logic [NUM_OUT-1:0]       sel_err
);

   localparam int CNT_W = $clog2(MUTE_TICKS + 2);
   // The tick that detects the change is itself the first midscale tick.
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((MUTE_TICKS > 0) ? MUTE_TICKS - 1 : 0);

   logic v1_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         v1_q      <= sample_en;
         out_valid <= v1_q;
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
      localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(k % NUM_IN);

      logic [SEL_W-1:0] req;
      logic             req_ok;
      ch_state_t        state_q, state_d;
      logic [SEL_W-1:0] active_q, active_d;
      logic [SEL_W-1:0] pending_q, pending_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [SEL_W-1:0] src;
      logic             mid;
      logic [IN_W-1:0]  word_q;
      logic [1:0]       mode_q;
      logic             m4_q;
      logic             mid_q;
      logic             mute_out_q;

      assign req        = sel[k*SEL_W +: SEL_W];
      assign req_ok     = 32'(req) < NUM_IN;
      assign sel_err[k] = !req_ok;
      assign muting[k]  = mute_out_q;

      always_comb begin
         state_d   = state_q;
         active_d  = active_q;
         pending_d = pending_q;
         cnt_d     = cnt_q;
         src       = active_q;
         mid       = 1'b0;
         case (state_q)
            ST_RUN: begin
               if (req_ok && req != active_q) begin
                  if (MUTE_TICKS == 0) begin
                     active_d = req;
                     src      = req;
                  end else begin
                     mid = 1'b1;
                     if (CNT_RELOAD == '0) begin
                        active_d = req;
                     end else begin
                        pending_d = req;
                        cnt_d     = CNT_RELOAD;
                        state_d   = ST_MUTE;
                     end
                  end
               end
            end
            ST_MUTE: begin
               mid = 1'b1;
               if (req_ok && req != pending_q) begin
                  pending_d = req;
                  cnt_d     = CNT_RELOAD;
               end else if (cnt_q == CNT_W'(1)) begin
                  active_d = pending_q;
                  cnt_d    = '0;
                  state_d  = ST_RUN;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = ST_RUN;
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q    <= ST_RUN;
            active_q   <= RST_SEL;
            pending_q  <= RST_SEL;
            cnt_q      <= '0;
            word_q     <= '0;
            mode_q     <= MODE_BIPOLAR;
            m4_q       <= 1'b0;
            mid_q      <= 1'b0;
            mute_out_q <= 1'b0;
         end else begin
            if (sample_en) begin
               state_q   <= state_d;
               active_q  <= active_d;
               pending_q <= pending_d;
               cnt_q     <= cnt_d;
               word_q    <= data_in[src*IN_W +: IN_W];
               mode_q    <= in_mode[src*2 +: 2];
               m4_q      <= sym_m4[src];
               mid_q     <= mid;
            end
            if (v1_q) mute_out_q <= mid_q;
         end
      end

      dac_sample_conv #(
         .IN_W  (IN_W),
         .DAC_W (DAC_W)
      ) u_conv (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (v1_q),
         .mute  (mid_q),
         .mode  (mode_q),
         .m4    (m4_q),
         .word  (word_q),
         .code  (data_out[k*DAC_W +: DAC_W])
      );
   end

endmodule

// File: tb/tb_dac_route_mux.sv
// Bench for dac_route_mux: vector table, hand-written mute/reset sequences, random run vs tick model.
module tb_dac_route_mux;

   localparam int NI  = 8;
   localparam int NO  = 2;
   localparam int IW  = 32;
   localparam int DW  = 12;
   localparam int MT  = 4;
   localparam int MID = 2048;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sample_en = 1'b0;
   logic [NI*IW-1:0]  data_in = '0;
   logic [2*NI-1:0]   in_mode = '0;
   logic [NI-1:0]     sym_m4 = '0;
   logic [NO*3-1:0]   sel = 6'b001_000;
   logic [NO*DW-1:0]  data_out;
   logic              out_valid;
   logic [NO-1:0]     muting;
   logic [NO-1:0]     sel_err;

   logic [NO*3-1:0]   sel6 = 6'b001_000;
   logic [NO*DW-1:0]  data_out6;
   logic              out_valid6;
   logic [NO-1:0]     muting6;
   logic [NO-1:0]     sel_err6;

   always #5 clk = ~clk;

   dac_route_mux #(.NUM_IN(NI), .NUM_OUT(NO), .IN_W(IW), .DAC_W(DW), .MUTE_TICKS(MT)) u_main (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in), .in_mode(in_mode),
      .sym_m4(sym_m4), .sel(sel), .data_out(data_out), .out_valid(out_valid), .muting(muting),
      .sel_err(sel_err));

   dac_route_mux #(.NUM_IN(6), .NUM_OUT(NO), .IN_W(IW), .DAC_W(DW), .MUTE_TICKS(0)) u_six (
      .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in[6*IW-1:0]),
      .in_mode(in_mode[11:0]), .sym_m4(sym_m4[5:0]), .sel(sel6), .data_out(data_out6),
      .out_valid(out_valid6), .muting(muting6), .sel_err(sel_err6));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Tick-level reference: cur = routed source, tgt = source waiting, left = midscale ticks still owed.
   int cur[NO], tgt[NO], left[NO];
   int nxt_code[NO];
   bit nxt_mute[NO];
   bit pend_v = 0;
   int pend_code[NO], last_code[NO];
   bit pend_mute[NO], last_mute[NO];
   int obs0[$], obs1[$];
   bit obsm1[$];

   function automatic int ref_conv(input int src);
      logic [1:0]  md;
      logic [31:0] w;
      int          sv;
      md = in_mode[src*2 +: 2];
      w  = data_in[src*IW +: IW];
      case (md)
         2'd1: return (w > 32'd4095) ? 4095 : int'(w);
         2'd2: return sym_m4[src] ? int'(w[1:0]) * (4095 / 3) : (w[0] ? 4095 : 0);
         default: begin
            sv = signed'(w);
            if (sv < -2048) return 0;
            if (sv > 2047) return 4095;
            return sv + 2048;
         end
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NO; k++) begin
         cur[k] = k % NI; tgt[k] = k % NI; left[k] = 0;
      end
   endtask

   task automatic model_tick();
      int s;
      for (int k = 0; k < NO; k++) begin
         s = int'(sel[k*3 +: 3]);
         if (s < NI) begin
            if (left[k] == 0) begin
               if (s != cur[k]) begin
                  if (MT == 0) cur[k] = s;
                  else begin tgt[k] = s; left[k] = MT; end
               end
            end else if (s != tgt[k]) begin
               tgt[k] = s; left[k] = MT;
            end
         end
         if (left[k] > 0) begin
            nxt_code[k] = MID; nxt_mute[k] = 1'b1;
            left[k]--;
            if (left[k] == 0) cur[k] = tgt[k];
         end else begin
            nxt_code[k] = ref_conv(cur[k]); nxt_mute[k] = 1'b0;
         end
      end
   endtask

   task automatic cyc(input bit en);
      bit exp_v;
      sample_en = en;
      if (en && rst_n) model_tick();
      @(posedge clk); #1;
      exp_v = rst_n ? pend_v : 1'b0;
      if (!rst_n) begin
         model_reset();
         for (int k = 0; k < NO; k++) begin last_code[k] = MID; last_mute[k] = 1'b0; end
      end else if (pend_v) begin
         for (int k = 0; k < NO; k++) begin last_code[k] = pend_code[k]; last_mute[k] = pend_mute[k]; end
         obs0.push_back(int'(data_out[0 +: DW]));
         obs1.push_back(int'(data_out[DW +: DW]));
         obsm1.push_back(muting[1]);
      end
      chk("out_valid", out_valid, exp_v);
      for (int k = 0; k < NO; k++) begin
         chk($sformatf("data_out[%0d]", k), data_out[k*DW +: DW], last_code[k]);
         chk($sformatf("muting[%0d]", k), muting[k], last_mute[k]);
         chk($sformatf("sel_err[%0d]", k), sel_err[k], sel[k*3 +: 3] >= NI);
      end
      pend_v = en && rst_n;
      for (int k = 0; k < NO; k++) begin pend_code[k] = nxt_code[k]; pend_mute[k] = nxt_mute[k]; end
   endtask

   task automatic set_in(input int i, input logic [1:0] md, input bit m4, input logic [31:0] w);
      data_in[i*IW +: IW] = w;
      in_mode[i*2 +: 2]   = md;
      sym_m4[i]           = m4;
   endtask

   task automatic rand_in(input int i);
      logic [31:0] w;
      case ($urandom_range(0, 2))
         0: w = $urandom;
         1: w = 32'($urandom_range(0, 6000)) - 32'd3000;
         default: w = 32'($urandom_range(0, 5000));
      endcase
      set_in(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
   endtask

   typedef struct {
      logic [1:0]  md;
      bit          m4;
      logic [31:0] w;
      int          exp;
   } vec_t;

   vec_t tbl[16];
   int   exp_seq[$];
   bit   exp_mseq[$];

   initial begin
      tbl[0]  = '{2'd0, 1'b0, -32'sd100,    1948};
      tbl[1]  = '{2'd0, 1'b0, 32'd5000,     4095};
      tbl[2]  = '{2'd0, 1'b0, -32'sd5000,   0};
      tbl[3]  = '{2'd0, 1'b0, 32'd0,        2048};
      tbl[4]  = '{2'd2, 1'b1, 32'd0,        0};
      tbl[5]  = '{2'd2, 1'b1, 32'd1,        1365};
      tbl[6]  = '{2'd2, 1'b1, 32'd2,        2730};
      tbl[7]  = '{2'd2, 1'b1, 32'd3,        4095};
      tbl[8]  = '{2'd2, 1'b0, 32'd2,        0};
      tbl[9]  = '{2'd2, 1'b0, 32'd3,        4095};
      tbl[10] = '{2'd1, 1'b0, 32'd70000,    4095};
      tbl[11] = '{2'd3, 1'b0, -32'sd100,    1948};
      tbl[12] = '{2'd2, 1'b1, 32'hFFFF_FFFE, 2730};
      tbl[13] = '{2'd1, 1'b0, 32'd4095,     4095};
      tbl[14] = '{2'd0, 1'b0, 32'd2047,     4095};
      tbl[15] = '{2'd0, 1'b0, -32'sd2048,   0};

      model_reset();
      for (int k = 0; k < NO; k++) begin last_code[k] = MID; last_mute[k] = 1'b0; end

      // Reset and first sample after release.
      rst_n = 1'b0;
      cyc(0); cyc(0);
      chk("rst_data0", data_out[0 +: DW], MID);
      chk("rst_data1", data_out[DW +: DW], MID);
      chk("rst_valid", out_valid, 0);
      rst_n = 1'b1;
      set_in(0, 2'd1, 1'b0, 32'd777);
      set_in(1, 2'd1, 1'b0, 32'd111);
      set_in(3, 2'd1, 1'b0, 32'd333);
      set_in(5, 2'd1, 1'b0, 32'd555);
      set_in(2, 2'd1, 1'b0, 32'd222);
      cyc(1); cyc(0);
      chk("first_ch0", data_out[0 +: DW], 777);
      chk("first_ch1", data_out[DW +: DW], 111);

      // Conversion vectors on in0 / ch0, with two-cycle latency.
      for (int i = 0; i < 16; i++) begin
         set_in(0, tbl[i].md, tbl[i].m4, tbl[i].w);
         cyc(1);
         chk($sformatf("tbl%0d_early_valid", i), out_valid, 0);
         cyc(0);
         chk($sformatf("tbl%0d_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_code", i), data_out[0 +: DW], tbl[i].exp);
         cyc(0);
      end

      // Back-to-back bipolar burst.
      obs0.delete();
      set_in(0, 2'd0, 1'b0, -32'sd100);  cyc(1);
      set_in(0, 2'd0, 1'b0, 32'd5000);   cyc(1);
      set_in(0, 2'd0, 1'b0, -32'sd5000); cyc(1);
      set_in(0, 2'd0, 1'b0, 32'd0);      cyc(1);
      cyc(0); cyc(0);
      exp_seq = '{1948, 4095, 0, 2048};
      chk("burst_len", obs0.size(), 4);
      for (int i = 0; i < 4 && i < obs0.size(); i++) chk($sformatf("burst%0d", i), obs0[i], exp_seq[i]);

      // Mute on ch1: 1 -> 3, ch0 keeps running.
      set_in(0, 2'd1, 1'b0, 32'd777);
      cyc(1); cyc(0); cyc(0);
      obs0.delete(); obs1.delete(); obsm1.delete();
      sel[5:3] = 3'd3;
      for (int i = 0; i < 6; i++) cyc(1);
      cyc(0); cyc(0);
      exp_seq  = '{2048, 2048, 2048, 2048, 333, 333};
      exp_mseq = '{1, 1, 1, 1, 0, 0};
      chk("mute_len", obs1.size(), 6);
      for (int i = 0; i < 6 && i < obs1.size(); i++) begin
         chk($sformatf("mute_code%0d", i), obs1[i], exp_seq[i]);
         chk($sformatf("mute_flag%0d", i), obsm1[i], exp_mseq[i]);
         chk($sformatf("mute_ch0_%0d", i), obs0[i], 777);
      end

      // Re-select during mute restarts the countdown: 3 -> 1, then 5 on the 2nd muted tick.
      obs1.delete(); obsm1.delete();
      sel[5:3] = 3'd1;
      cyc(1);
      sel[5:3] = 3'd5;
      for (int i = 0; i < 6; i++) cyc(1);
      cyc(0); cyc(0);
      exp_seq  = '{2048, 2048, 2048, 2048, 2048, 555, 555};
      exp_mseq = '{1, 1, 1, 1, 1, 0, 0};
      chk("resel_len", obs1.size(), 7);
      for (int i = 0; i < 7 && i < obs1.size(); i++) begin
         chk($sformatf("resel_code%0d", i), obs1[i], exp_seq[i]);
         chk($sformatf("resel_flag%0d", i), obsm1[i], exp_mseq[i]);
      end

      // Reset in the middle of a mute.
      sel[5:3] = 3'd1;
      cyc(1); cyc(1);
      rst_n = 1'b0;
      cyc(0); cyc(0);
      chk("rstmid_data1", data_out[DW +: DW], MID);
      chk("rstmid_mute", muting, 0);
      chk("rstmid_valid", out_valid, 0);
      rst_n = 1'b1;
      cyc(1); cyc(0);
      chk("rstmid_ch0", data_out[0 +: DW], 777);
      chk("rstmid_ch1", data_out[DW +: DW], 111);
      chk("rstmid_flag", muting[1], 0);

      // Six-input instance, no mute: invalid select ignored, valid change immediate.
      sel6[2:0] = 3'd7;
      #1;
      chk("inv_sel_err", sel_err6, 2'b01);
      cyc(1); cyc(0);
      chk("inv_valid", out_valid6, 1);
      chk("inv_keep", data_out6[0 +: DW], 777);
      chk("inv_nomute", muting6, 0);
      sel6[2:0] = 3'd2;
      #1;
      chk("valid_sel_err", sel_err6, 2'b00);
      cyc(1); cyc(0);
      chk("imm_switch", data_out6[0 +: DW], 222);
      chk("imm_nomute", muting6, 0);
      chk("imm_ch1", data_out6[DW +: DW], 111);

      // Randomised traffic against the tick model.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NI; i++) if ($urandom_range(0, 9) == 0) rand_in(i);
         for (int k = 0; k < NO; k++)
            if ($urandom_range(0, 11) == 0) sel[k*3 +: 3] = 3'($urandom_range(0, 7));
         cyc($urandom_range(0, 3) != 0);
      end
      cyc(0); cyc(0); cyc(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
